// File: rtl/core_pkg.sv
// Shared definitions for the integer back end: ALU opcodes, the issue payload
// width and the reservation-station entry record.
package core_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0100;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_OR   = 4'b1100;
  localparam logic [3:0] ALU_AND  = 4'b1110;

  localparam int EXEC_PAYLOAD_W = 76;

  typedef struct packed {
    logic        valid;
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic [31:0] op1;
    logic        op1_ready;
    logic [4:0]  op1_tag;
    logic [31:0] op2;
    logic        op2_ready;
    logic [4:0]  op2_tag;
  } rs_entry_t;

endpackage

// File: rtl/rs_select.sv
// Lowest-index find-first over an N-bit request vector.
module rs_select #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_vec,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  // Scan from the top so the last hit written is the lowest index.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_found = 1'b1;
        o_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/rs_integer.sv
// Integer reservation station: buffers dispatched ops, snoops the result bus
// for pending operands and issues the lowest-index ready op each cycle.
module rs_integer
  import core_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dispatch_valid,
  output logic                      dispatch_ready,
  input  logic [3:0]                dispatch_aluop,
  input  logic [4:0]                dispatch_rd,
  input  logic [31:0]               dispatch_op1,
  input  logic [31:0]               dispatch_op2,
  input  logic                      dispatch_op1_ready,
  input  logic                      dispatch_op2_ready,
  input  logic [4:0]                dispatch_op1_tag,
  input  logic [4:0]                dispatch_op2_tag,
  input  logic                      wb_valid,
  input  logic [4:0]                wb_rd,
  input  logic [31:0]               wb_data,
  input  logic                      flush,
  output logic                      start,
  output logic [EXEC_PAYLOAD_W-1:0] rs,
  output logic [IDX_W:0]            occupancy
);

  rs_entry_t                 r_ent [DEPTH];
  logic [IDX_W:0]            r_occ;
  logic                      r_start;
  logic [EXEC_PAYLOAD_W-1:0] r_rs;

  logic [DEPTH-1:0]          w_free, w_elig;
  logic                      w_free_found, w_iss_found;
  logic [IDX_W-1:0]          w_free_idx, w_iss_idx;
  logic                      w_dispatch, w_wb_hit, w_byp1, w_byp2;
  rs_entry_t                 w_new;
  logic [EXEC_PAYLOAD_W-1:0] w_payload;

  always_comb begin
    w_free = '0;
    w_elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_free[i] = !r_ent[i].valid;
      w_elig[i] = r_ent[i].valid && r_ent[i].op1_ready && r_ent[i].op2_ready;
    end
  end

  rs_select #(.N(DEPTH)) u_free_sel (.i_vec(w_free), .o_found(w_free_found), .o_idx(w_free_idx));
  rs_select #(.N(DEPTH)) u_iss_sel  (.i_vec(w_elig), .o_found(w_iss_found),  .o_idx(w_iss_idx));

  assign dispatch_ready = (r_occ != (IDX_W+1)'(DEPTH));
  assign w_dispatch     = dispatch_valid && dispatch_ready && w_free_found;
  assign w_wb_hit       = wb_valid && (wb_rd != 5'd0);
  assign w_byp1         = w_wb_hit && !dispatch_op1_ready && (dispatch_op1_tag == wb_rd);
  assign w_byp2         = w_wb_hit && !dispatch_op2_ready && (dispatch_op2_tag == wb_rd);

  // New entry with the same-cycle broadcast folded in, so it cannot miss its producer.
  always_comb begin
    w_new           = '0;
    w_new.valid     = 1'b1;
    w_new.aluop     = dispatch_aluop;
    w_new.rd        = dispatch_rd;
    w_new.op1       = w_byp1 ? wb_data : dispatch_op1;
    w_new.op1_ready = dispatch_op1_ready || w_byp1;
    w_new.op1_tag   = dispatch_op1_tag;
    w_new.op2       = w_byp2 ? wb_data : dispatch_op2;
    w_new.op2_ready = dispatch_op2_ready || w_byp2;
    w_new.op2_tag   = dispatch_op2_tag;
  end

  assign w_payload = {r_ent[w_iss_idx].aluop, r_ent[w_iss_idx].rd, 3'b000,
                      r_ent[w_iss_idx].op1, r_ent[w_iss_idx].op2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
      r_occ   <= '0;
      r_start <= 1'b0;
      r_rs    <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
      r_occ   <= '0;
      r_start <= 1'b0;
      r_rs    <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wb_hit && r_ent[i].valid && !r_ent[i].op1_ready && r_ent[i].op1_tag == wb_rd) begin
          r_ent[i].op1       <= wb_data;
          r_ent[i].op1_ready <= 1'b1;
        end
        if (w_wb_hit && r_ent[i].valid && !r_ent[i].op2_ready && r_ent[i].op2_tag == wb_rd) begin
          r_ent[i].op2       <= wb_data;
          r_ent[i].op2_ready <= 1'b1;
        end
      end
      r_start <= w_iss_found;
      if (w_iss_found) begin
        r_rs                   <= w_payload;
        r_ent[w_iss_idx].valid <= 1'b0;
      end
      // Free slot comes from registered valids, so it never aliases the issuing entry.
      if (w_dispatch) r_ent[w_free_idx] <= w_new;
      r_occ <= r_occ + (IDX_W+1)'(w_dispatch) - (IDX_W+1)'(w_iss_found);
    end
  end

  assign start     = r_start;
  assign rs        = r_rs;
  assign occupancy = r_occ;

endmodule

// File: tb/tb_rs_integer.sv
// Directed and randomized checks of rs_integer against an entry-array model.
module tb_rs_integer;

  localparam int DEPTH = 4;
  localparam int IDX_W = $clog2(DEPTH);

  logic        clk, reset;
  logic        dispatch_valid, dispatch_ready;
  logic [3:0]  dispatch_aluop;
  logic [4:0]  dispatch_rd;
  logic [31:0] dispatch_op1, dispatch_op2;
  logic        dispatch_op1_ready, dispatch_op2_ready;
  logic [4:0]  dispatch_op1_tag, dispatch_op2_tag;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        flush;
  logic        start;
  logic [75:0] rs;
  logic [IDX_W:0] occupancy;

  rs_integer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_aluop(dispatch_aluop), .dispatch_rd(dispatch_rd),
    .dispatch_op1(dispatch_op1), .dispatch_op2(dispatch_op2),
    .dispatch_op1_ready(dispatch_op1_ready), .dispatch_op2_ready(dispatch_op2_ready),
    .dispatch_op1_tag(dispatch_op1_tag), .dispatch_op2_tag(dispatch_op2_tag),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .start(start), .rs(rs), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: one slot per entry, plus the last issued payload.
  bit          m_v  [DEPTH];
  logic [3:0]  m_alu[DEPTH];
  logic [4:0]  m_rd [DEPTH];
  logic [31:0] m_o1 [DEPTH], m_o2 [DEPTH];
  bit          m_r1 [DEPTH], m_r2 [DEPTH];
  logic [4:0]  m_t1 [DEPTH], m_t2 [DEPTH];
  bit          m_start;
  logic [75:0] m_rs;
  logic [75:0] exp_rs;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_v[i]);
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
    m_start = 0;
    m_rs    = '0;
  endtask

  task automatic model_edge();
    int iss = -1;
    int fr  = -1;
    bit dsp;
    if (flush) begin
      model_reset();
      return;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (iss < 0 && m_v[i] && m_r1[i] && m_r2[i]) iss = i;
      if (fr < 0 && !m_v[i]) fr = i;
    end
    dsp = dispatch_valid && (m_count() < DEPTH);
    if (iss >= 0) begin
      m_start = 1;
      m_rs    = {m_alu[iss], m_rd[iss], 3'b000, m_o1[iss], m_o2[iss]};
      m_v[iss] = 0;
    end else m_start = 0;
    if (wb_valid && wb_rd != 0)
      for (int i = 0; i < DEPTH; i++) if (m_v[i]) begin
        if (!m_r1[i] && m_t1[i] == wb_rd) begin m_o1[i] = wb_data; m_r1[i] = 1; end
        if (!m_r2[i] && m_t2[i] == wb_rd) begin m_o2[i] = wb_data; m_r2[i] = 1; end
      end
    if (dsp) begin
      m_v[fr] = 1; m_alu[fr] = dispatch_aluop; m_rd[fr] = dispatch_rd;
      m_o1[fr] = dispatch_op1; m_r1[fr] = dispatch_op1_ready; m_t1[fr] = dispatch_op1_tag;
      m_o2[fr] = dispatch_op2; m_r2[fr] = dispatch_op2_ready; m_t2[fr] = dispatch_op2_tag;
      if (wb_valid && wb_rd != 0) begin
        if (!m_r1[fr] && m_t1[fr] == wb_rd) begin m_o1[fr] = wb_data; m_r1[fr] = 1; end
        if (!m_r2[fr] && m_t2[fr] == wb_rd) begin m_o2[fr] = wb_data; m_r2[fr] = 1; end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("start", 76'(start), 76'(m_start));
    chk("rs", rs, m_rs);
    chk("occupancy", 76'(occupancy), 76'(m_count()));
    chk("dispatch_ready", 76'(dispatch_ready), 76'(m_count() < DEPTH));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    dispatch_valid = 0; wb_valid = 0; flush = 0;
  endtask

  task automatic disp(input logic [3:0] alu, input logic [4:0] rd,
                      input logic [31:0] o1, input bit r1, input logic [4:0] t1,
                      input logic [31:0] o2, input bit r2, input logic [4:0] t2);
    dispatch_valid = 1; dispatch_aluop = alu; dispatch_rd = rd;
    dispatch_op1 = o1; dispatch_op1_ready = r1; dispatch_op1_tag = t1;
    dispatch_op2 = o2; dispatch_op2_ready = r2; dispatch_op2_tag = t2;
  endtask

  task automatic bcast(input logic [4:0] rd, input logic [31:0] d);
    wb_valid = 1; wb_rd = rd; wb_data = d;
  endtask

  initial begin
    reset = 1; idle();
    dispatch_aluop = 0; dispatch_rd = 0; dispatch_op1 = 0; dispatch_op2 = 0;
    dispatch_op1_ready = 0; dispatch_op2_ready = 0; dispatch_op1_tag = 0; dispatch_op2_tag = 0;
    wb_rd = 0; wb_data = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 0;

    // Ready dispatch: issue one edge after acceptance.
    disp(4'b0000, 5'd5, 32'd3, 1, 0, 32'd4, 1, 0);
    step();
    idle(); step();
    exp_rs = {4'b0000, 5'd5, 3'b000, 32'd3, 32'd4};
    chk("ready_issue_start", 76'(start), 76'd1);
    chk("ready_issue_rs", rs, exp_rs);
    step();
    chk("ready_issue_drop", 76'(start), 76'd0);

    // Wakeup through the result bus.
    disp(4'b0001, 5'd6, 32'd0, 0, 5'd5, 32'd1, 1, 0);
    step();
    idle(); step(); step();
    bcast(5'd5, 32'd10); step();
    chk("wake_same_edge", 76'(start), 76'd0);
    idle(); step();
    exp_rs = {4'b0001, 5'd6, 3'b000, 32'd10, 32'd1};
    chk("wake_issue_rs", rs, exp_rs);
    step();

    // Same-cycle bypass into the dispatching entry.
    disp(4'b0000, 5'd8, 32'd0, 0, 5'd7, 32'd2, 1, 0);
    bcast(5'd7, 32'hDEAD);
    step();
    idle(); step();
    exp_rs = {4'b0000, 5'd8, 3'b000, 32'hDEAD, 32'd2};
    chk("bypass_rs", rs, exp_rs);
    step();

    // A broadcast to x0 must not wake a tag-0 wait.
    disp(4'b0000, 5'd9, 32'd0, 0, 5'd0, 32'd1, 1, 0);
    step();
    idle(); bcast(5'd0, 32'h55); step();
    idle(); step(); step();
    chk("x0_no_wake", 76'(start), 76'd0);
    flush = 1; step(); idle();

    // Full station: a fifth dispatch is dropped.
    for (int i = 0; i < DEPTH; i++) begin
      disp(4'b1000, 5'(20 + i), 32'd0, 0, 5'(11 + i), 32'(i), 1, 0);
      step();
    end
    chk("full_occ", 76'(occupancy), 76'd4);
    chk("full_ready", 76'(dispatch_ready), 76'd0);
    disp(4'b1100, 5'd30, 32'd1, 1, 0, 32'd1, 1, 0);
    step();
    chk("full_ignored", 76'(occupancy), 76'd4);
    idle(); bcast(5'd13, 32'h1234); step();
    idle(); step();
    exp_rs = {4'b1000, 5'd22, 3'b000, 32'h1234, 32'd2};
    chk("full_wake_rs", rs, exp_rs);
    chk("full_ready_again", 76'(dispatch_ready), 76'd1);
    flush = 1; step(); idle();

    // Priority: entries 1 and 3 become eligible together.
    disp(4'b0010, 5'd1, 32'd0, 0, 5'd20, 32'd0, 1, 0); step();
    disp(4'b0100, 5'd2, 32'd0, 0, 5'd16, 32'd0, 1, 0); step();
    disp(4'b0110, 5'd3, 32'd0, 0, 5'd20, 32'd0, 1, 0); step();
    disp(4'b1010, 5'd4, 32'd0, 0, 5'd16, 32'd0, 1, 0); step();
    idle(); bcast(5'd16, 32'h77); step();
    idle(); step();
    exp_rs = {4'b0100, 5'd2, 3'b000, 32'h77, 32'd0};
    chk("prio_first", rs, exp_rs);
    step();
    exp_rs = {4'b1010, 5'd4, 3'b000, 32'h77, 32'd0};
    chk("prio_second", rs, exp_rs);
    bcast(5'd20, 32'h99); step();
    idle(); flush = 1; step();
    chk("flush_start", 76'(start), 76'd0);
    chk("flush_occ", 76'(occupancy), 76'd0);
    idle();

    // Async reset between edges with entries held.
    disp(4'b1110, 5'd10, 32'd0, 0, 5'd25, 32'd0, 1, 0); step();
    disp(4'b1110, 5'd11, 32'd0, 0, 5'd26, 32'd0, 1, 0); step();
    disp(4'b1110, 5'd12, 32'd0, 0, 5'd27, 32'd0, 1, 0); step();
    idle();
    #2 reset = 1;
    #1;
    model_reset();
    check_all();
    @(posedge clk); #1;
    reset = 0;
    check_all();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      logic [4:0] t1, t2;
      t1 = 5'($urandom_range(0, 7));
      t2 = 5'($urandom_range(0, 7));
      disp(4'($urandom), 5'($urandom_range(1, 31)),
           $urandom, (t1 == 0) || ($urandom_range(0, 1) == 1), t1,
           $urandom, (t2 == 0) || ($urandom_range(0, 1) == 1), t2);
      dispatch_valid = ($urandom_range(0, 2) != 0);
      wb_valid = ($urandom_range(0, 1) == 1);
      wb_rd    = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      flush    = ($urandom_range(0, 39) == 0);
      step();
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
